tdnn_layer_sequencer: RTL and testbench

//  Controller for one TDNN layer of NEURON_LIN instances. Loads weights and biases from a shared

---
 rtl/tdnn_pkg.sv | 28 ++
 rtl/tdnn_tap_line.sv | 52 +++++
 rtl/tdnn_layer_sequencer.sv | 162 ++++++++++++++++
 tb/tb_tdnn_layer_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdnn_pkg.sv
// Shared types and sizing helpers for the TDNN layer sequencer.
// Address width and words-per-neuron are derived here so the top and bench agree.
package tdnn_pkg;

   localparam int unsigned DefSigSize    = 16;
   localparam int unsigned DefWeightSize = 16;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StWb,
      StReady,
      StCompute
   } tdnn_state_e;

   // Each neuron owns NUM_INPUTS weight words followed by one bias word.
   function automatic int unsigned words_per_neuron(input int unsigned num_inputs);
      return num_inputs + 1;
   endfunction

   function automatic int unsigned addr_w(input int unsigned num_neurons,
                                          input int unsigned num_inputs);
      int unsigned words;
      words = num_neurons * words_per_neuron(num_inputs);
      return (words > 1) ? int'($clog2(words)) : 1;
   endfunction

endpackage

// File: rtl/tdnn_tap_line.sv
// Time-delay tap line feeding NEURON_IN of every neuron; tap 0 holds the newest sample.
// Also tracks how many valid samples are in the line, saturating at the line depth.
module tdnn_tap_line
   import tdnn_pkg::*;
#(
   parameter int unsigned SigSize   = DefSigSize,
   parameter int unsigned NumInputs = 3,
   parameter int unsigned FillW     = $clog2(NumInputs + 1)
) (
   input  logic                              clk_n_i,
   input  logic                              rst_i,
   input  logic                              clr_i,
   input  logic                              shift_i,
   input  logic [SigSize-1:0]                sample_i,
   output logic [NumInputs-1:0][SigSize-1:0] taps_o,
   output logic [FillW-1:0]                  fill_o
);

   logic [NumInputs-1:0][SigSize-1:0] taps_q, taps_d;
   logic [FillW-1:0]                  fill_q, fill_d;

   always_comb begin
      taps_d = taps_q;
      fill_d = fill_q;
      if (clr_i) begin
         taps_d = '0;
         fill_d = '0;
      end else if (shift_i) begin
         taps_d[0] = sample_i;
         for (int i = 1; i < NumInputs; i++) begin
            taps_d[i] = taps_q[i-1];
         end
         if (fill_q != FillW'(NumInputs)) begin
            fill_d = fill_q + FillW'(1);
         end
      end
   end

   always_ff @(negedge clk_n_i) begin
      if (rst_i) begin
         taps_q <= '0;
         fill_q <= '0;
      end else begin
         taps_q <= taps_d;
         fill_q <= fill_d;
      end
   end

   assign taps_o = taps_q;
   assign fill_o = fill_q;

endmodule

// File: rtl/tdnn_layer_sequencer.sv
// Sequencer for one TDNN layer: streams weights/biases into each neuron, then paces
// sample acceptance to the neuron latency and flags when the layer outputs are valid.
module tdnn_layer_sequencer
   import tdnn_pkg::*;
#(
   parameter int unsigned SigSize    = DefSigSize,
   parameter int unsigned WeightSize = DefWeightSize,
   parameter int unsigned NumInputs  = 3,
   parameter int unsigned NumNeurons = 4,
   parameter int unsigned NeuronLat  = 2,
   parameter int unsigned AddrW      = addr_w(NumNeurons, NumInputs)
) (
   input  logic                                 clk_n_i,
   input  logic                                 rst_i,
   input  logic                                 cfg_start_i,
   output logic [AddrW-1:0]                     mem_addr_o,
   input  logic [WeightSize-1:0]                mem_data_i,
   output logic [NumInputs-1:0][WeightSize-1:0] weights_o,
   output logic [WeightSize-1:0]                bias_o,
   output logic [NumNeurons-1:0]                wb_en_o,
   output logic                                 cfg_done_o,
   input  logic                                 in_valid_i,
   input  logic [SigSize-1:0]                   in_sample_i,
   output logic                                 in_ready_o,
   output logic [NumInputs-1:0][SigSize-1:0]    taps_o,
   output logic                                 out_valid_o,
   output logic                                 busy_o
);

   localparam int unsigned Wpn     = words_per_neuron(NumInputs);
   localparam int unsigned WordW   = $clog2(Wpn + 1);
   localparam int unsigned NeurW   = (NumNeurons > 1) ? $clog2(NumNeurons) : 1;
   localparam int unsigned LatW    = (NeuronLat > 1) ? $clog2(NeuronLat) : 1;
   localparam int unsigned FillW   = $clog2(NumInputs + 1);

   tdnn_state_e                         state_q, state_d;
   logic [WordW-1:0]                    word_q, word_d;
   logic [NeurW-1:0]                    neuron_q, neuron_d;
   logic [LatW-1:0]                     lat_q, lat_d;
   logic [AddrW-1:0]                    addr_q, addr_d;
   logic [NumInputs-1:0][WeightSize-1:0] weights_q, weights_d;
   logic [WeightSize-1:0]               bias_q, bias_d;
   logic                                cfg_done_q, cfg_done_d;
   logic                                out_valid_q, out_valid_d;
   logic                                tap_clr, tap_shift;
   logic [FillW-1:0]                    fill;

   tdnn_tap_line #(
      .SigSize  (SigSize),
      .NumInputs(NumInputs),
      .FillW    (FillW)
   ) u_tap_line (
      .clk_n_i (clk_n_i),
      .rst_i   (rst_i),
      .clr_i   (tap_clr),
      .shift_i (tap_shift),
      .sample_i(in_sample_i),
      .taps_o  (taps_o),
      .fill_o  (fill)
   );

   always_ff @(negedge clk_n_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         word_q      <= '0;
         neuron_q    <= '0;
         lat_q       <= '0;
         addr_q      <= '0;
         weights_q   <= '0;
         bias_q      <= '0;
         cfg_done_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         neuron_q    <= neuron_d;
         lat_q       <= lat_d;
         addr_q      <= addr_d;
         weights_q   <= weights_d;
         bias_q      <= bias_d;
         cfg_done_q  <= cfg_done_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      neuron_d    = neuron_q;
      lat_d       = lat_q;
      addr_d      = addr_q;
      weights_d   = weights_q;
      bias_d      = bias_q;
      cfg_done_d  = 1'b0;
      out_valid_d = 1'b0;
      tap_clr     = 1'b0;
      tap_shift   = 1'b0;
      unique case (state_q)
         StIdle, StReady: begin
            // A reload request beats a simultaneous sample.
            if (cfg_start_i) begin
               state_d  = StLoad;
               word_d   = '0;
               neuron_d = '0;
               addr_d   = '0;
               tap_clr  = 1'b1;
            end else if (state_q == StReady && in_valid_i) begin
               state_d   = StCompute;
               lat_d     = '0;
               tap_shift = 1'b1;
            end
         end
         StLoad: begin
            // Read data lags the address by one cycle, so word_q-1 is arriving now.
            for (int k = 0; k < NumInputs; k++) begin
               if (word_q == WordW'(k + 1)) weights_d[k] = mem_data_i;
            end
            if (word_q == WordW'(Wpn)) bias_d = mem_data_i;
            if (word_q < WordW'(Wpn - 1)) addr_d = addr_q + AddrW'(1);
            if (word_q == WordW'(Wpn)) begin
               state_d = StWb;
            end else begin
               word_d = word_q + WordW'(1);
            end
         end
         StWb: begin
            if (neuron_q == NeurW'(NumNeurons - 1)) begin
               state_d    = StReady;
               cfg_done_d = 1'b1;
            end else begin
               state_d  = StLoad;
               neuron_d = neuron_q + NeurW'(1);
               word_d   = '0;
               addr_d   = addr_q + AddrW'(1);
            end
         end
         StCompute: begin
            if (lat_q == LatW'(NeuronLat - 1)) begin
               state_d     = StReady;
               out_valid_d = (fill == FillW'(NumInputs));
            end else begin
               lat_d = lat_q + LatW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      mem_addr_o  = addr_q;
      weights_o   = weights_q;
      bias_o      = bias_q;
      cfg_done_o  = cfg_done_q;
      out_valid_o = out_valid_q;
      in_ready_o  = (state_q == StReady);
      busy_o      = (state_q == StLoad) || (state_q == StWb) || (state_q == StCompute);
      for (int n = 0; n < NumNeurons; n++) begin
         wb_en_o[n] = (state_q == StWb) && (neuron_q == NeurW'(n));
      end
   end

endmodule

// File: tb/tb_tdnn_layer_sequencer.sv
// Scoreboard bench for tdnn_layer_sequencer: a cycle-timeline model predicts load strobes,
// config-done and output-valid events; a monitor pops and compares them as they appear.
module tb_tdnn_layer_sequencer;

   localparam int unsigned SigSize    = 16;
   localparam int unsigned WeightSize = 16;
   localparam int unsigned NumInputs  = 3;
   localparam int unsigned NumNeurons = 2;
   localparam int unsigned NeuronLat  = 2;
   localparam int unsigned AddrW      = 3;
   localparam int         Wpn         = NumInputs + 1;
   localparam int         NeuronCyc   = NumInputs + 3;
   localparam int         CfgCycles   = NumNeurons * NeuronCyc;

   typedef logic [NumInputs-1:0][SigSize-1:0]    taps_t;
   typedef logic [NumInputs-1:0][WeightSize-1:0] wts_t;
   typedef struct {
      int                    stamp;
      logic [NumNeurons-1:0] en;
      wts_t                  w;
      logic [WeightSize-1:0] b;
   } wb_t;
   typedef struct {
      int    stamp;
      taps_t t;
   } ov_t;

   logic                  clk_n = 1'b1;
   logic                  rst = 1'b0, cfg_start = 1'b0, in_valid = 1'b0;
   logic [SigSize-1:0]    in_sample = '0;
   logic [WeightSize-1:0] mem_data = '0;
   logic [AddrW-1:0]      mem_addr;
   wts_t                  weights;
   logic [WeightSize-1:0] bias;
   logic [NumNeurons-1:0] wb_en;
   logic                  cfg_done, in_ready, out_valid, busy;
   taps_t                 taps;

   int    n_vec = 0, n_err = 0, cyc = 0;
   bit    mon_en = 1'b0;
   // Reference model state: edges at or after free_at see the layer idle/ready.
   bit    cfgd = 1'b0;
   int    free_at = 0, cfg_s = -1, addr_hold = 0, mfill = 0;
   taps_t mtaps = '0;
   wb_t   exp_wb[$];
   int    exp_done[$];
   ov_t   exp_ov[$];

   tdnn_layer_sequencer #(
      .SigSize   (SigSize),
      .WeightSize(WeightSize),
      .NumInputs (NumInputs),
      .NumNeurons(NumNeurons),
      .NeuronLat (NeuronLat),
      .AddrW     (AddrW)
   ) dut (
      .clk_n_i    (clk_n),
      .rst_i      (rst),
      .cfg_start_i(cfg_start),
      .mem_addr_o (mem_addr),
      .mem_data_i (mem_data),
      .weights_o  (weights),
      .bias_o     (bias),
      .wb_en_o    (wb_en),
      .cfg_done_o (cfg_done),
      .in_valid_i (in_valid),
      .in_sample_i(in_sample),
      .in_ready_o (in_ready),
      .taps_o     (taps),
      .out_valid_o(out_valid),
      .busy_o     (busy)
   );

   always #5 clk_n = ~clk_n;

   always @(negedge clk_n) mem_data <= WeightSize'(16'h0100 + 16'(mem_addr));

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at edge %0d: got %h, expected %h", name, cyc, got, exp);
      end
   endtask

   function automatic int exp_addr();
      int d;
      d = cyc - cfg_s;
      if (cfg_s >= 0 && d < CfgCycles) return (d / NeuronCyc) * Wpn + ((d % NeuronCyc < Wpn - 1) ? d % NeuronCyc : Wpn - 1);
      return addr_hold;
   endfunction

   task automatic model();
      wb_t w;
      ov_t o;
      if (rst) begin
         cfgd = 1'b0; free_at = 0; cfg_s = -1; addr_hold = 0; mfill = 0; mtaps = '0;
         exp_wb.delete(); exp_done.delete(); exp_ov.delete();
      end else if (cyc >= free_at) begin
         if (cfg_start) begin
            for (int n = 0; n < NumNeurons; n++) begin
               w.stamp = cyc + n * NeuronCyc + NeuronCyc - 1;
               w.en    = NumNeurons'(1 << n);
               for (int k = 0; k < NumInputs; k++) w.w[k] = WeightSize'(16'h0100 + n * Wpn + k);
               w.b     = WeightSize'(16'h0100 + n * Wpn + NumInputs);
               exp_wb.push_back(w);
            end
            exp_done.push_back(cyc + CfgCycles);
            free_at = cyc + CfgCycles + 1;
            cfgd = 1'b1; cfg_s = cyc; addr_hold = NumNeurons * Wpn - 1;
            mtaps = '0; mfill = 0;
         end else if (cfgd && in_valid) begin
            for (int i = NumInputs - 1; i > 0; i--) mtaps[i] = mtaps[i-1];
            mtaps[0] = in_sample;
            if (mfill < NumInputs) mfill++;
            free_at = cyc + NeuronLat + 1;
            if (mfill == NumInputs) begin
               o.stamp = cyc + NeuronLat;
               o.t     = mtaps;
               exp_ov.push_back(o);
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clk_n);
      cyc++;
      model();
      #1;
   endtask

   function automatic bit ready_next();
      return cfgd && (cyc + 1 >= free_at);
   endfunction

   task automatic send(input logic [SigSize-1:0] s);
      bit sent;
      sent = 1'b0;
      for (int i = 0; i < 40 && !sent; i++) begin
         if (ready_next()) begin
            in_valid = 1'b1; in_sample = s;
            sent = 1'b1;
         end else begin
            in_valid = 1'($urandom_range(0, 1)); in_sample = 16'hBEEF;
         end
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic reload();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         if (ready_next()) begin
            cfg_start = 1'b1; in_valid = 1'b1; in_sample = 16'h7777;
            done = 1'b1;
         end
         tick();
         cfg_start = 1'b0; in_valid = 1'b0;
      end
   endtask

   // Monitor: continuous status checks plus scoreboard pops on strobe/pulse outputs.
   initial begin
      bit                    eb;
      logic [NumNeurons-1:0] een;
      logic                  edone, eov;
      forever begin
         @(posedge clk_n);
         if (mon_en) begin
            eb = (cyc + 1 < free_at);
            chk("busy", 64'(busy), 64'(eb));
            chk("in_ready", 64'(in_ready), 64'(cfgd && !eb));
            chk("taps", 64'(taps), 64'(mtaps));
            chk("mem_addr", 64'(mem_addr), 64'(exp_addr()));
            while (exp_wb.size() > 0 && exp_wb[0].stamp < cyc) void'(exp_wb.pop_front());
            while (exp_done.size() > 0 && exp_done[0] < cyc) void'(exp_done.pop_front());
            while (exp_ov.size() > 0 && exp_ov[0].stamp < cyc) void'(exp_ov.pop_front());
            een = '0;
            if (exp_wb.size() > 0 && exp_wb[0].stamp == cyc) begin
               een = exp_wb[0].en;
               chk("weights", 64'(weights), 64'(exp_wb[0].w));
               chk("bias", 64'(bias), 64'(exp_wb[0].b));
               void'(exp_wb.pop_front());
            end
            chk("wb_en", 64'(wb_en), 64'(een));
            edone = 1'b0;
            if (exp_done.size() > 0 && exp_done[0] == cyc) begin
               edone = 1'b1;
               void'(exp_done.pop_front());
            end
            chk("cfg_done", 64'(cfg_done), 64'(edone));
            eov = 1'b0;
            if (exp_ov.size() > 0 && exp_ov[0].stamp == cyc) begin
               eov = 1'b1;
               chk("ov_taps", 64'(taps), 64'(exp_ov[0].t));
               void'(exp_ov.pop_front());
            end
            chk("out_valid", 64'(out_valid), 64'(eov));
         end
      end
   end

   initial begin
      rst = 1'b1;
      tick();
      mon_en = 1'b1;
      tick();
      rst = 1'b0;
      // Samples offered before any configuration are ignored.
      in_valid = 1'b1; in_sample = 16'hBEEF;
      repeat (3) tick();
      in_valid = 1'b0;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      in_valid = 1'b1;
      repeat (5) tick();
      in_valid = 1'b0;
      send(16'h1000); send(16'h2000); send(16'h3000); send(16'h4000);
      send(16'h5000);
      // Reload request while computing is dropped.
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      send(16'h6000);
      reload();
      send(16'hA001); send(16'hA002); send(16'hA003);
      // Reset part-way through a load.
      reload();
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = 1'b1; in_sample = 16'hBEEF;
      repeat (6) tick();
      in_valid = 1'b0;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      send(16'hC001); send(16'hC002); send(16'hC003); send(16'hC004);
      for (int i = 0; i < 2000; i++) begin
         rst       = ($urandom_range(0, 149) == 0);
         cfg_start = ($urandom_range(0, 29) == 0);
         in_valid  = 1'($urandom_range(0, 1));
         in_sample = SigSize'($urandom);
         tick();
      end
      rst = 1'b0; cfg_start = 1'b0; in_valid = 1'b0;
      repeat (30) tick();
      chk("wb_left", 64'(exp_wb.size()), 64'd0);
      chk("done_left", 64'(exp_done.size()), 64'd0);
      chk("ov_left", 64'(exp_ov.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
